// File: rtl/ysyx_210544_rtc_cal_pkg.sv
// Shared definitions for the calendar RTC: register map, CTRL bit positions,
// the TIME/ALARM field layout and the default reset time.
package ysyx_210544_rtc_cal_pkg;

    localparam int BUS_64 = 64;

    localparam logic [1:0] ADDR_TIME  = 2'd0;
    localparam logic [1:0] ADDR_ALARM = 2'd1;
    localparam logic [1:0] ADDR_CTRL  = 2'd2;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_ALARM_EN = 1;
    localparam int CTRL_PEND     = 2;
    localparam int CTRL_WR_ERR   = 3;

    localparam int SEC_LSB  = 0;
    localparam int SEC_W    = 6;
    localparam int MIN_LSB  = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_LSB = 12;
    localparam int HOUR_W   = 6;
    localparam int DAY_LSB  = 18;
    localparam int DAY_W    = 5;
    localparam int MON_LSB  = 23;
    localparam int MON_W    = 4;
    localparam int YEAR_LSB = 27;
    localparam int YEAR_W   = 16;
    localparam int TIME_W   = YEAR_LSB + YEAR_W;

    typedef struct packed {
        logic [YEAR_W-1:0] year;
        logic [MON_W-1:0]  month;
        logic [DAY_W-1:0]  day;
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } rtc_time_t;

    // 2021-01-02 03:04:05
    localparam logic [BUS_64-1:0] DEFAULT_RESET_TIME =
        {21'b0, 16'd2021, 4'd1, 5'd2, 6'd3, 6'd4, 6'd5};

    function automatic logic [BUS_64-1:0] pack_time(input rtc_time_t t);
        return {{(BUS_64-TIME_W){1'b0}}, t};
    endfunction

endpackage

// File: rtl/ysyx_210544_rtc_cal_if.sv
// Peripheral bus bundle between the core side (master) and the RTC (slave).
interface ysyx_210544_rtc_cal_if;
    import ysyx_210544_rtc_cal_pkg::*;

    logic                ren;
    logic                wen;
    logic [1:0]          addr;
    logic [BUS_64-1:0]   wdata;
    logic [BUS_64-1:0]   rdata;
    logic                irq;

    modport master (output ren, output wen, output addr, output wdata,
                    input rdata, input irq);
    modport slave  (input ren, input wen, input addr, input wdata,
                    output rdata, output irq);
endinterface

// File: rtl/ysyx_210544_rtc_dim.sv
// Days-in-month lookup with the Gregorian leap-year rule.
module ysyx_210544_rtc_dim (
    input  logic [15:0] year,
    input  logic [3:0]  month,
    output logic [4:0]  dim
);
    logic leap;

    assign leap = (year[1:0] == 2'b00) &&
                  (((year % 16'd100) != 16'd0) || ((year % 16'd400) == 16'd0));

    always_comb begin
        dim = 5'd31;
        case (month)
            4'd2:                      dim = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
            default:                   dim = 5'd31;
        endcase
    end
endmodule

// File: rtl/ysyx_210544_rtc_cal.sv
// Calendar RTC: prescaler, second-to-year carry chain, writable TIME/ALARM
// with field validation, CTRL with W1C status bits and a registered read port.
module ysyx_210544_rtc_cal
    import ysyx_210544_rtc_cal_pkg::*;
#(
    parameter int                CLOCKS_PER_SECOND = 1000000,
    parameter logic [BUS_64-1:0] RESET_TIME        = DEFAULT_RESET_TIME
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_210544_rtc_cal_if.slave bus
);
    localparam int PW = (CLOCKS_PER_SECOND > 2) ? $clog2(CLOCKS_PER_SECOND) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCKS_PER_SECOND - 1);

    rtc_time_t         cur;
    rtc_time_t         nxt;
    rtc_time_t         alarm;
    rtc_time_t         wtime;
    logic [PW-1:0]     presc;
    logic              run;
    logic              alarm_en;
    logic              alarm_pend;
    logic              wr_err;
    logic [4:0]        dim_cur;
    logic [4:0]        dim_w;
    logic              tick;
    logic              wvalid;
    logic              wr_time;
    logic              wr_alarm;
    logic              wr_ctrl;
    logic              load_time;
    logic              alarm_hit;
    logic [BUS_64-1:0] rd_mux;
    logic [BUS_64-1:0] rdata_p1;
    logic              unused_wdata;

    assign wtime        = bus.wdata[TIME_W-1:0];
    assign unused_wdata = ^bus.wdata[BUS_64-1:TIME_W];

    ysyx_210544_rtc_dim u_dim_cur (.year(cur.year),   .month(cur.month),   .dim(dim_cur));
    ysyx_210544_rtc_dim u_dim_wr  (.year(wtime.year), .month(wtime.month), .dim(dim_w));

    assign wvalid = (wtime.year <= 16'd9999) &&
                    (wtime.month >= 4'd1) && (wtime.month <= 4'd12) &&
                    (wtime.day >= 5'd1) && (wtime.day <= dim_w) &&
                    (wtime.hour <= 6'd23) && (wtime.minute <= 6'd59) &&
                    (wtime.second <= 6'd59);

    assign wr_time   = bus.wen && (bus.addr == ADDR_TIME);
    assign wr_alarm  = bus.wen && (bus.addr == ADDR_ALARM);
    assign wr_ctrl   = bus.wen && (bus.addr == ADDR_CTRL);
    assign load_time = wr_time && wvalid;
    assign tick      = run && (presc == PRESC_MAX);
    // A valid TIME write drops the coincident tick, so it can never raise the alarm.
    assign alarm_hit = tick && !load_time && (nxt == alarm);

    always_comb begin
        nxt = cur;
        if (cur.second == 6'd59) begin
            nxt.second = 6'd0;
            if (cur.minute == 6'd59) begin
                nxt.minute = 6'd0;
                if (cur.hour == 6'd23) begin
                    nxt.hour = 6'd0;
                    if (cur.day >= dim_cur) begin
                        nxt.day = 5'd1;
                        if (cur.month == 4'd12) begin
                            nxt.month = 4'd1;
                            nxt.year  = (cur.year == 16'd9999) ? 16'd0 : cur.year + 16'd1;
                        end else begin
                            nxt.month = cur.month + 4'd1;
                        end
                    end else begin
                        nxt.day = cur.day + 5'd1;
                    end
                end else begin
                    nxt.hour = cur.hour + 6'd1;
                end
            end else begin
                nxt.minute = cur.minute + 6'd1;
            end
        end else begin
            nxt.second = cur.second + 6'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_TIME:  rd_mux = pack_time(cur);
            ADDR_ALARM: rd_mux = pack_time(alarm);
            ADDR_CTRL:  rd_mux = {{(BUS_64-4){1'b0}}, wr_err, alarm_pend, alarm_en, run};
            default:    rd_mux = '0;
        endcase
    end

    // Stage p0 -> p1: state update and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= RESET_TIME[TIME_W-1:0];
            alarm      <= '0;
            presc      <= '0;
            run        <= 1'b1;
            alarm_en   <= 1'b0;
            alarm_pend <= 1'b0;
            wr_err     <= 1'b0;
            rdata_p1   <= '0;
        end else begin
            rdata_p1 <= bus.ren ? rd_mux : '0;

            if (load_time) begin
                cur   <= wtime;
                presc <= '0;
            end else if (run) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    cur <= nxt;
                end
            end

            if (wr_alarm && wvalid) begin
                alarm <= wtime;
            end

            if (wr_ctrl) begin
                run      <= bus.wdata[CTRL_RUN];
                alarm_en <= bus.wdata[CTRL_ALARM_EN];
            end

            if (alarm_hit) begin
                alarm_pend <= 1'b1;
            end else if (wr_ctrl && bus.wdata[CTRL_PEND]) begin
                alarm_pend <= 1'b0;
            end

            if ((wr_time || wr_alarm) && !wvalid) begin
                wr_err <= 1'b1;
            end else if (wr_ctrl && bus.wdata[CTRL_WR_ERR]) begin
                wr_err <= 1'b0;
            end
        end
    end

    assign bus.rdata = rdata_p1;
    assign bus.irq   = alarm_pend && alarm_en;
endmodule

// File: tb/tb_ysyx_210544_rtc_cal.sv
// Directed bench for the calendar RTC with a 4-cycle second.
module tb_ysyx_210544_rtc_cal;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] v;

    always #5 clk = ~clk;

    ysyx_210544_rtc_cal_if bus ();

    ysyx_210544_rtc_cal #(.CLOCKS_PER_SECOND(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] mk(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
        return {21'b0, 16'(y), 4'(mo), 5'(d), 6'(h), 6'(mi), 6'(s)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        bus.wen   = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.wen   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [63:0] d);
        bus.ren  = 1'b1;
        bus.addr = a;
        @(negedge clk);
        bus.ren  = 1'b0;
        d = bus.rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic roll(input string tag, input logic [63:0] start, input logic [63:0] exp);
        logic [63:0] r;
        wr(2'd0, start);
        idle(4);
        rd(2'd0, r);
        check(tag, r, exp);
    endtask

    initial begin
        bus.ren = 1'b0; bus.wen = 1'b0; bus.addr = 2'd0; bus.wdata = '0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("rst_irq", 64'(bus.irq), 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        rd(2'd0, v); check("rst_time", v, mk(2021, 1, 2, 3, 4, 5));
        rd(2'd2, v); check("rst_ctrl", v, 64'h1);
        idle(2);
        rd(2'd0, v); check("first_tick", v, mk(2021, 1, 2, 3, 4, 6));
        idle(1);
        check("rdata_idle", bus.rdata, 64'd0);
        rd(2'd3, v); check("rd_reserved", v, 64'd0);

        roll("leap_2024", mk(2024, 2, 28, 23, 59, 59), mk(2024, 2, 29, 0, 0, 0));
        roll("nonleap_2023", mk(2023, 2, 28, 23, 59, 59), mk(2023, 3, 1, 0, 0, 0));
        roll("leap_2000", mk(2000, 2, 28, 23, 59, 59), mk(2000, 2, 29, 0, 0, 0));
        roll("nonleap_2100", mk(2100, 2, 28, 23, 59, 59), mk(2100, 3, 1, 0, 0, 0));
        roll("year_wrap", mk(9999, 12, 31, 23, 59, 59), mk(0, 1, 1, 0, 0, 0));

        wr(2'd0, mk(2021, 6, 15, 10, 20, 30));
        wr(2'd1, mk(2021, 6, 15, 10, 20, 32));
        wr(2'd2, 64'h3);
        idle(5);
        check("irq_before", 64'(bus.irq), 64'd0);
        idle(1);
        check("irq_rise", 64'(bus.irq), 64'd1);
        rd(2'd2, v); check("ctrl_pend", v, 64'h7);
        wr(2'd2, 64'h7);
        check("irq_clear", 64'(bus.irq), 64'd0);
        rd(2'd2, v); check("ctrl_after_w1c", v, 64'h3);

        wr(2'd0, mk(2022, 4, 10, 8, 0, 0));
        wr(2'd2, 64'h0);
        idle(20);
        rd(2'd0, v); check("freeze", v, mk(2022, 4, 10, 8, 0, 0));
        wr(2'd0, mk(2022, 13, 10, 8, 0, 0));
        rd(2'd0, v); check("bad_month_time", v, mk(2022, 4, 10, 8, 0, 0));
        rd(2'd2, v); check("bad_month_err", v, 64'h8);
        wr(2'd2, 64'h8);
        rd(2'd2, v); check("err_clear", v, 64'h0);
        wr(2'd0, mk(2022, 4, 31, 8, 0, 0));
        rd(2'd0, v); check("bad_day_time", v, mk(2022, 4, 10, 8, 0, 0));
        rd(2'd2, v); check("bad_day_err", v, 64'h8);
        wr(2'd2, 64'h8);
        wr(2'd1, mk(2022, 4, 31, 0, 0, 0));
        rd(2'd1, v); check("bad_alarm_kept", v, mk(2021, 6, 15, 10, 20, 32));
        rd(2'd2, v); check("bad_alarm_err", v, 64'h8);
        wr(2'd2, 64'h9);
        rd(2'd2, v); check("ctrl_0x9", v, 64'h1);

        wr(2'd0, mk(2022, 1, 1, 0, 0, 0));
        idle(3);
        wr(2'd0, mk(2022, 5, 5, 5, 5, 5));
        rd(2'd0, v); check("tick_write", v, mk(2022, 5, 5, 5, 5, 5));
        idle(2);
        rd(2'd0, v); check("tick_write_hold", v, mk(2022, 5, 5, 5, 5, 5));
        rd(2'd0, v); check("tick_write_next", v, mk(2022, 5, 5, 5, 5, 6));

        wr(2'd2, 64'h3);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_irq", 64'(bus.irq), 64'd0);
        rd(2'd0, v); check("midrst_time", v, mk(2021, 1, 2, 3, 4, 5));
        rd(2'd2, v); check("midrst_ctrl", v, 64'h1);
        rd(2'd1, v); check("midrst_alarm", v, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_210544_rtc_cal.md
# ysyx_210544_rtc_cal

Parametrised calendar real-time clock: a second-granularity timekeeper with a configurable prescaler, correct Gregorian month lengths and leap years, software-writable time, and a one-shot alarm interrupt. Sits on the SoC peripheral bus beside the CLINT. It gives the core a readable, settable wall clock plus an alarm IRQ for the interrupt controller.

## Interface
Parameters:
- `CLOCKS_PER_SECOND`, default 1000000: `clk` cycles per RTC second. Must be ≥ 2.
- `RESET_TIME`, default packed 2021-01-02 03:04:05: time loaded at reset, in TIME format.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ren`  in  1  read strobe.
- `wen`  in  1  write strobe.
- `addr`  in  2  register select: 0 TIME, 1 ALARM, 2 CTRL, 3 reserved.
- `wdata`  in  64  write data.
- `rdata`  out  64  registered read data.
- `irq`  out  1  alarm interrupt, level.

## Operation
- TIME/ALARM format: {21'b0, year[15:0], month[3:0], day[4:0], hour[5:0], minute[5:0], second[5:0]}.
- Field ranges: month 1–12, day 1–dim, hour 0–23, minute and second 0–59, year 0–9999.
- CTRL bits:
  - [0] run (R/W). Reset value 1.
  - [1] alarm_en (R/W). Reset value 0.
  - [2] alarm_pend (R, write-1-to-clear).
  - [3] wr_err (R, write-1-to-clear, sticky).
  - All other bits read 0.
- Prescaler: counter `presc` runs 0…CLOCKS_PER_SECOND-1 while run=1. A tick fires when it equals CLOCKS_PER_SECOND-1, and presc returns to 0. With run=0, presc holds.
- Tick carry chain:
  - second 59→0 carries into minute.
  - minute 59→0 carries into hour.
  - hour 23→0 carries into day.
  - day dim→1 carries into month.
  - month 12→1 carries into year.
  - year 9999→0.
- dim (days in month) = 31/28/31/30/31/30/31/31/30/31/30/31. February is 29 when the year is a leap year: year%4==0 and (year%100!=0 or year%400==0).
- Write to TIME:
  - All fields are validated.
  - Valid: TIME is loaded and presc is cleared to 0.
  - Invalid: no change, and wr_err is set.
- Write to ALARM: same validation and wr_err behaviour; presc is unaffected.
- Alarm: when a tick produces a new TIME equal to ALARM, set alarm_pend. Writes to TIME never set it.
- irq = alarm_pend & alarm_en.
- Writes to addr 3 are ignored. Reads of addr 3 return 0.

## Timing
- Reset values:
  - TIME = RESET_TIME, ALARM = 0, presc = 0.
  - CTRL = 0x1.
  - rdata = 0, irq = 0.
- Reads:
  - rdata is registered. With `ren` high in cycle N, rdata holds the selected register in cycle N+1. The value is the state before any same-cycle write or tick.
  - rdata = 0 in any cycle after `ren` was low.
- Writes take effect at the clock edge of the `wen` cycle and are visible to a read issued the next cycle.
- A tick and a TIME write in the same cycle: the write wins, the tick is dropped, and presc = 0.
- Alarm match and a W1C of alarm_pend in the same cycle: set wins.
- `ren` and `wen` both high: both are performed, and the read returns the pre-write value.
- `rst` mid-operation: all state returns to reset values on the next edge, regardless of the other inputs.
- Alarm latency: irq rises on the edge after the tick cycle (the same edge TIME updates), and stays high until cleared.

## Structure
- Shared defines/package holds:
  - register address constants (TIME, ALARM, CTRL);
  - CTRL bit indices;
  - TIME field offsets and widths;
  - `BUS_64`.
- One sub-module, `ysyx_210544_rtc_dim`:
  - combinational, input year[15:0] and month[3:0], output dim[4:0], including the leap rule;
  - shared by the carry logic and write validation.
  - The top instantiates it twice: once for the current TIME, once for `wdata`.
- The top holds the prescaler, carry chain, register file, validation, and read mux/register.

## Test plan
All scenarios use CLOCKS_PER_SECOND=4.
- Reset, then read TIME → 2021-01-02 03:04:05. Read CTRL → 0x1. irq = 0. After 4 cycles, TIME second = 6.
- Write TIME 2024-02-28 23:59:59, wait one tick → 2024-02-29 00:00:00. Repeat with 2023 → 2023-03-01.
- Write 2000-02-28 23:59:59 → tick gives 02-29. Write 2100-02-28 23:59:59 → tick gives 2100-03-01. Write 9999-12-31 23:59:59 → tick gives 0000-01-01 00:00:00.
- Set ALARM = TIME+2 s and CTRL = 0x3. irq rises exactly at the second tick. Write CTRL with 0x7 → pend clears and irq = 0 next cycle.
- Write TIME with month=13, then day=31 in April → TIME unchanged and CTRL[3] = 1. Write CTRL 0x9 → wr_err cleared.
- CTRL = 0 (run off) for 20 cycles → TIME frozen. Issue a TIME write on the exact tick cycle → written value held and presc = 0. Assert rst mid-count → reset values restored.
